ysyx_22050612_ifu_pipe: RTL
===========================

# ysyx_22050612_ifu_pipe

Parametrised instruction-fetch unit for the NPC core. It holds the architectural fetch PC with a configurable reset vector and issues one fetch at a time to instruction memory over a valid/ready request and valid response interface. It presents each fetched instruction to decode through a valid/ready skid register. It accepts redirects from branch/jump resolution at any time and discards any in-flight response made stale by a redirect.

## Interface
Parameters:
- XLEN, 64, PC and address width
- INST_W, 32, instruction width
- RESET_PC, 64'h8000_0000, PC loaded on reset (truncated to XLEN)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
- redirect_valid  in  1  load new PC this cycle
- redirect_pc  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (= pc)
- imem_rsp_valid  in  1  response data valid (one per accepted request, ≥1 cycle after acceptance)
- imem_rsp_data  in  INST_W  fetched instruction
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode consumes instruction
- inst  out  INST_W  instruction
- inst_pc  out  XLEN  PC of inst
- pc  out  XLEN  current fetch PC

## Operation
- States: REQ, WAIT, HOLD, DRAIN. Reset: state=REQ, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0.
- REQ: imem_req_valid=1, imem_req_addr=pc. On imem_req_ready go to WAIT.
- WAIT: imem_req_valid=0. On imem_rsp_valid: inst<=imem_rsp_data, inst_pc<=pc, inst_valid<=1, go to HOLD.
- HOLD: inst_valid=1, inst/inst_pc stable. On inst_ready: inst_valid<=0, pc<=pc+4 (mod 2^XLEN, wraps silently), go to REQ.
- DRAIN: imem_req_valid=0, waiting for a stale response. On imem_rsp_valid: discard data, go to REQ.
- Redirect (highest priority, any state): pc<={redirect_pc[XLEN-1:2],2'b00}; inst_valid<=0. Next state:
  - REQ if current state is REQ without handshake this cycle, or HOLD
  - DRAIN if current state is WAIT without imem_rsp_valid, or REQ with imem_req_ready this cycle
  - REQ if current state is WAIT with imem_rsp_valid this cycle (response discarded)
  - DRAIN stays DRAIN unless imem_rsp_valid, then REQ
- Redirect in HOLD with inst_ready=1: the handshake completes but pc takes redirect_pc, not pc+4.
- At most one outstanding request; imem_req_valid never asserted in WAIT/DRAIN/HOLD.
- imem_req_valid, once asserted, holds with stable addr until accepted or a redirect occurs.
- imem_rsp_valid outside WAIT/DRAIN is ignored.
- rst low overrides everything, including mid-fetch; a response arriving after reset is ignored, because the state is REQ.

## Timing
- All outputs are registered state or decoded from state/pc only; there is no combinational in→out path.
- Best-case loop (ready and response each one cycle later): REQ handshake at cycle t, response at t+1, inst_valid=1 at t+2, inst_ready at t+2, next request at t+3. This gives one instruction per 3 cycles.
- Redirect takes effect on the next edge: imem_req_addr=redirect target one cycle later (from REQ/HOLD), or after the stale response drains.
- inst_valid deasserts the cycle after a redirect; decode never sees a wrong-path instruction after that edge.

## Test plan
- Reset: hold rst=0 for 2 cycles, release -> pc=imem_req_addr=0x80000000, imem_req_valid=1, inst_valid=0.
- Sequential fetch with always-ready memory, 1-cycle response, inst_ready=1 -> inst_pc sequence 0x80000000, 0x80000004, 0x80000008, with inst matching memory words, one every 3 cycles.
- Backpressure: inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, no new request; the fetch at pc+4 is issued the cycle after inst_ready=1.
- Redirect in WAIT to 0x80001003 -> the stale response is dropped (inst_valid stays 0); the next request address is 0x80001000.
- Redirect in HOLD coincident with inst_ready=1 -> the next request address is the target, not inst_pc+4.
- Wrap: redirect to 0xFFFF_FFFF_FFFF_FFFC, consume -> next fetch address is 0x0. Also assert rst=0 during WAIT -> the response is ignored and the request restarts at RESET_PC.

Source files
------------

// File: rtl/ysyx_22050612_ifu_pipe_if.sv
// Fetch-unit bus bundle: redirect input, imem request/response channel and
// the decode-side instruction handshake, plus the architectural fetch PC.
interface ysyx_22050612_ifu_pipe_if #(
  parameter int XLEN   = 64,
  parameter int INST_W = 32
);
  logic              redirect_valid;
  logic [XLEN-1:0]   redirect_pc;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_rsp_valid;
  logic [INST_W-1:0] imem_rsp_data;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [XLEN-1:0]   inst_pc;
  logic [XLEN-1:0]   pc;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, pc
  );
endinterface

// File: rtl/ysyx_22050612_ifu_pipe.sv
// Instruction-fetch unit: one outstanding imem request, a single-entry
// instruction register toward decode, and redirect handling with stale-response drain.
module ysyx_22050612_ifu_pipe #(
  parameter int          XLEN     = 64,
  parameter int          INST_W   = 32,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input logic                       clk,
  input logic                       rst,
  ysyx_22050612_ifu_pipe_if.master  bus
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_e;

  localparam logic [XLEN-1:0] PC_RST     = XLEN'(RESET_PC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [XLEN-1:0]   inst_pc_q, inst_pc_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_REQ;
      pc_q         <= PC_RST;
      inst_pc_q    <= '0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_pc_q    <= inst_pc_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_pc_d    = inst_pc_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;

    unique case (state_q)
      S_REQ: begin
        if (bus.imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d       = bus.imem_rsp_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          state_d      = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.inst_ready) begin
          inst_valid_d = 1'b0;
          pc_d         = pc_q + XLEN'(4);
          state_d      = S_REQ;
        end
      end
      S_DRAIN: begin
        if (bus.imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // Redirect overrides the per-state update; a request already accepted
    // (or still in flight) must be drained before the new target is fetched.
    if (bus.redirect_valid) begin
      pc_d         = bus.redirect_pc & ALIGN_MASK;
      inst_valid_d = 1'b0;
      inst_d       = inst_q;
      inst_pc_d    = inst_pc_q;
      unique case (state_q)
        S_REQ:   state_d = bus.imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  assign bus.imem_req_valid = (state_q == S_REQ);
  assign bus.imem_req_addr  = pc_q;
  assign bus.pc             = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;

endmodule
